// File: rtl/pixel_lane_packer.sv
// Decimates a raster pixel stream and packs LANES kept pixels per packet for a multi-lane sender.
// Define PIXEL_LANE_PACKER_ROW_FLUSH_EN to zero-fill and emit a partial packet at the end of a row.
module pixel_lane_packer #(
  parameter int unsigned PIXEL_WIDTH = 16,
  parameter int unsigned LANES       = 6,
  parameter int unsigned DECIM       = 2,
  parameter int unsigned HRES        = 1280
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         pixel_valid_in,
  input  logic [PIXEL_WIDTH-1:0]       pixel_data_in,
  input  logic [10:0]                  hcount_in,
  input  logic [9:0]                   vcount_in,
  input  logic                         packet_ready_in,
  output logic                         packet_valid_out,
  output logic [LANES*PIXEL_WIDTH-1:0] packet_data_out,
  output logic                         packet_sof_out,
  output logic                         overflow_out,
  output logic [15:0]                  drop_count_out
);

  localparam int unsigned CntW    = $clog2(LANES + 1);
  localparam logic [10:0] HMask   = 11'(DECIM - 1);
  localparam logic [9:0]  VMask   = 10'(DECIM - 1);
  localparam logic [10:0] RowLast = 11'(HRES - DECIM);
`ifdef PIXEL_LANE_PACKER_ROW_FLUSH_EN
  localparam bit FlushEn = 1'b1;
`else
  localparam bit FlushEn = 1'b0;
`endif

  // Slot 0 lives in the most significant element so the packet maps straight onto the output.
  typedef logic [LANES-1:0][PIXEL_WIDTH-1:0] pkt_t;

  typedef enum logic {StFill, StHold} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] fill_q, fill_d;
  pkt_t            collect_q, collect_d;
  logic            col_sof_q, col_sof_d;
  logic            out_valid_q, out_valid_d;
  pkt_t            out_data_q, out_data_d;
  logic            out_sof_q, out_sof_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     drop_q, drop_d;

  logic            keep;
  logic            frame_start;
  logic            row_end;
  logic [CntW-1:0] base;
  logic [CntW-1:0] fill_new;
  pkt_t            pkt;
  logic            complete;
  logic            out_free;

  always_comb begin
    keep        = pixel_valid_in && ((hcount_in & HMask) == '0) && ((vcount_in & VMask) == '0);
    frame_start = keep && (hcount_in == '0) && (vcount_in == '0);
    row_end     = hcount_in == RowLast;
    base        = frame_start ? '0 : fill_q;
    fill_new    = base + CntW'(1);
    // Slots past the new fill level are cleared so a flushed packet carries zero lanes.
    for (int unsigned i = 0; i < LANES; i++) begin
      if (CntW'(i) == base) begin
        pkt[LANES-1-i] = pixel_data_in;
      end else if (CntW'(i) >= fill_new) begin
        pkt[LANES-1-i] = '0;
      end else begin
        pkt[LANES-1-i] = collect_q[LANES-1-i];
      end
    end
    complete = (fill_new == CntW'(LANES)) || (FlushEn && row_end);
    out_free = !out_valid_q || packet_ready_in;
  end

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    collect_d   = collect_q;
    col_sof_d   = col_sof_q;
    out_valid_d = out_valid_q && !packet_ready_in;
    out_data_d  = out_data_q;
    out_sof_d   = out_sof_q;
    overflow_d  = overflow_q;
    drop_d      = drop_q;

    unique case (state_q)
      StFill: begin
        if (keep) begin
          collect_d = pkt;
          fill_d    = fill_new;
          col_sof_d = frame_start || col_sof_q;
          if (complete) begin
            if (out_free) begin
              out_valid_d = 1'b1;
              out_data_d  = pkt;
              out_sof_d   = frame_start || col_sof_q;
              fill_d      = '0;
              col_sof_d   = 1'b0;
            end else begin
              state_d = StHold;
            end
          end
        end
      end
      StHold: begin
        if (keep) begin
          overflow_d = 1'b1;
          if (drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
          end
        end
        if (out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = collect_q;
          out_sof_d   = col_sof_q;
          fill_d      = '0;
          col_sof_d   = 1'b0;
          state_d     = StFill;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= StFill;
      fill_q      <= '0;
      collect_q   <= '0;
      col_sof_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sof_q   <= 1'b0;
      overflow_q  <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      collect_q   <= collect_d;
      col_sof_q   <= col_sof_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sof_q   <= out_sof_d;
      overflow_q  <= overflow_d;
      drop_q      <= drop_d;
    end
  end

  assign packet_valid_out = out_valid_q;
  assign packet_data_out  = out_data_q;
  assign packet_sof_out   = out_sof_q;
  assign overflow_out     = overflow_q;
  assign drop_count_out   = drop_q;

endmodule

// File: doc/pixel_lane_packer.md
PIXEL_LANE_PACKER -- requirements
Module: pixel_lane_packer

Interface
REQ-001 Parameter PIXEL_WIDTH, default 16: bits per pixel.
REQ-002 Parameter LANES, default 6: pixels per packet, one per SPI data line; legal range 1..16.
REQ-003 Parameter DECIM, default 2: decimation factor applied to both axes; legal values 1, 2, 4.
REQ-004 Parameter HRES, default 1280: input line width in pixels; a multiple of DECIM.
REQ-005 clk_in  input  1  sole clock; all logic on its rising edge.
REQ-006 rst_in  input  1  reset, asynchronous and active-high.
REQ-007 pixel_valid_in  input  1  pixel qualifier.
REQ-008 pixel_data_in  input  PIXEL_WIDTH  pixel value.
REQ-009 hcount_in  input  11  pixel column.
REQ-010 vcount_in  input  10  pixel row.
REQ-011 packet_ready_in  input  1  downstream SPI sender can accept a packet.
REQ-012 packet_valid_out  output  1  packet_data_out holds a complete packet.
REQ-013 packet_data_out  output  LANES*PIXEL_WIDTH  packet; first kept pixel in the most significant PIXEL_WIDTH bits.
REQ-014 packet_sof_out  output  1  the current packet starts a frame.
REQ-015 overflow_out  output  1  sticky flag: at least one kept pixel was dropped.
REQ-016 drop_count_out  output  16  count of dropped kept pixels; saturates at 65535.

Function
REQ-017 A pixel is kept when all three hold: pixel_valid_in=1, hcount_in mod DECIM = 0, and vcount_in mod DECIM = 0; every other pixel is ignored.
REQ-018 Storage is a collect register (LANES slots plus a fill counter) and one output register; states are FILL and HOLD.
REQ-019 In FILL, each kept pixel is written to the next slot and the fill counter increments; the LANES-th pixel completes the packet.
REQ-020 On completion, if the output register is empty or is being consumed in the same cycle (valid and ready both 1), the packet moves to the output register on the next edge and the state stays FILL; otherwise the state becomes HOLD.
REQ-021 Latency: packet_valid_out rises exactly 1 cycle after the LANES-th kept pixel, provided the output register is free.
REQ-022 In HOLD, the collect register moves to the output register in the cycle the output register frees, and the state returns to FILL.
REQ-023 A kept pixel arriving in HOLD is dropped: overflow_out is set and drop_count_out increments.
REQ-024 Handshake: a packet is consumed on any edge where packet_valid_out=1 and packet_ready_in=1; while unconsumed, packet_data_out and packet_sof_out hold stable.
REQ-025 Frame start, in FILL: a kept pixel with hcount_in=0 and vcount_in=0 discards any partial packet (not counted as a drop), is stored in slot 0, and tags the packet as SOF.
REQ-026 Frame start, in HOLD: the frame-start pixel is dropped per REQ-023.
REQ-027 Completion and consumption in the same cycle are legal and cause no bubble; sustained throughput is one packet per LANES kept pixels.

Reset
REQ-028 While rst_in=1: state is FILL, fill counter is 0, packet_valid_out=0, packet_sof_out=0, overflow_out=0, drop_count_out=0, packet_data_out=0.
REQ-029 A reset asserted mid-packet discards the partial packet and any pending output packet immediately, without waiting for a clock edge.

Configuration
REQ-030 Macro PIXEL_LANE_PACKER_ROW_FLUSH_EN enables row flushing.
REQ-031 With the macro defined: when the last kept pixel of a row (hcount_in = HRES-DECIM) leaves a partial packet, the remaining slots are zero-filled and the packet completes per REQ-020.
REQ-032 Without the macro: packets span row boundaries and only REQ-025 truncates them.

Verification
REQ-033 LANES=6, DECIM=2, ready held 1; stream row 0, hcount 0..11 -> one packet, pixels from hcount 0,2,4,6,8,10 with hcount 0 in the MSBs, sof=1, valid exactly 1 cycle after the hcount 10 pixel.
REQ-034 Ready held 0 after the first packet completes; feed 7 more kept pixels -> 6 fill collect (HOLD), 7th dropped, overflow_out=1, drop_count_out=1; raise ready -> the two packets are delivered in order.
REQ-035 Frame start after 3 kept pixels -> the partial packet is discarded, drop_count_out unchanged, the next packet begins with the frame-start pixel and has sof=1.
REQ-036 Macro defined, HRES=16, DECIM=2, LANES=6, one row -> packet 2 holds kept pixels 6,7 followed by four zero lanes; macro undefined -> packet 2 continues into the next kept row.
REQ-037 Assert rst_in asynchronously mid-packet with valid_out=1 -> valid_out=0 without a clock edge; after release, the next packet contains only post-reset pixels.
REQ-038 Stall for 65600 dropped pixels -> drop_count_out saturates at 65535.
